// File: rtl/gen_testdata_mc_pkg.sv
// Shared definitions for the multi-channel test-stream generator:
// pattern mode codes, controller states and PRBS31 polynomial taps.
package gen_testdata_mc_pkg;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_PRBS = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // x^31 + x^28 + 1 expressed as zero-based state bit indices
    localparam int PRBS_TAP_HI = 30;
    localparam int PRBS_TAP_LO = 27;

    localparam logic [30:0] PRBS_SEED_DEF = 31'h7FFFFFFF;

endpackage

// File: rtl/gen_testdata_mc_prbs.sv
// Combinational PRBS31 advance: steps the LFSR STEPS times and returns the
// new state plus the generated bits, first generated bit in the MSB.
module prbs31_step
    import gen_testdata_mc_pkg::*;
#(
    parameter int STEPS = 32
) (
    input  logic [30:0]      i_state,
    output logic [30:0]      o_state,
    output logic [STEPS-1:0] o_bits
);

    logic [30:0] w_s;
    logic        w_nb;

    always_comb begin
        w_s    = i_state;
        w_nb   = 1'b0;
        o_bits = '0;
        for (int i = 0; i < STEPS; i++) begin
            w_nb = w_s[PRBS_TAP_HI] ^ w_s[PRBS_TAP_LO];
            w_s  = {w_s[29:0], w_nb};
            o_bits[STEPS-1-i] = w_nb;
        end
        o_state = w_s;
    end

endmodule

// File: rtl/gen_testdata_mc.sv
// Paced, framed multi-channel test-stream generator with a one-word output
// register, ready backpressure, drop counting and counter/PRBS/walking patterns.
module gen_testdata_mc
    import gen_testdata_mc_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          NUM_CH     = 4,
    parameter int          PACE_DIV   = 47,
    parameter int          FRAME_LEN  = 100,
    parameter int          NUM_FRAMES = 0,
    parameter logic [30:0] PRBS_SEED  = PRBS_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_flag,
    input  logic              stop_flag,
    input  logic [1:0]        mode,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              last_out,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int                PACE_W     = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam int                IDX_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PACE_W-1:0] PACE_MAX   = PACE_W'(PACE_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [7:0]        CH_MAX     = 8'(NUM_CH - 1);
    localparam logic [15:0]       FRAMES_END = 16'(NUM_FRAMES);
    localparam logic [DATA_W-1:0] SEQ_MASK   = {8'h00, {(DATA_W-8){1'b1}}};
    localparam logic [DATA_W-1:0] ONE_HOT0   = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_mode;
    logic [31:0]         r_seq;
    logic [IDX_W-1:0]    r_word_idx;
    logic [7:0]          r_ch;
    logic [PACE_W-1:0]   r_pace;
    logic                r_tick;
    logic [30:0]         r_prbs;
    logic [30:0]         w_prbs_nxt;
    logic [DATA_W-1:0]   w_prbs_bits;
    logic [DATA_W-1:0]   w_word;
    logic                w_accept, w_pending, w_final_frame;
    logic                w_load_ok, w_load, w_drop;

    prbs31_step #(.STEPS(DATA_W)) u_prbs (
        .i_state (r_prbs),
        .o_state (w_prbs_nxt),
        .o_bits  (w_prbs_bits)
    );

    assign busy          = (r_state != ST_IDLE);
    assign w_accept      = valid_out && ready_in;
    assign w_pending     = valid_out && !w_accept;
    assign w_final_frame = (NUM_FRAMES != 0) && w_accept && last_out &&
                           (frame_cnt + 16'd1 == FRAMES_END);

    // A stop landing on a frame boundary, or the final frame completing, must
    // not open a new frame; in DRAIN loading ends once word_idx wraps to 0.
    assign w_load_ok = ((r_state == ST_RUN) && !(stop_flag && (r_word_idx == '0)) && !w_final_frame) ||
                       ((r_state == ST_DRAIN) && (r_word_idx != '0));
    assign w_load    = r_tick && w_load_ok && !w_pending;
    assign w_drop    = r_tick && w_load_ok && w_pending;

    always_comb begin
        w_word = (DATA_W'(r_ch) << (DATA_W - 8)) | (DATA_W'(r_seq) & SEQ_MASK);
        case (r_mode)
            MODE_PRBS: w_word = w_prbs_bits;
            MODE_WALK: w_word = ONE_HOT0 << (r_seq % DATA_W);
            default:   ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start_flag) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_final_frame)
                    w_state_nxt = ST_IDLE;
                else if (stop_flag)
                    w_state_nxt = ((r_word_idx != '0) || w_pending) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: if (w_accept && last_out) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_CNT;
            r_seq      <= '0;
            r_word_idx <= '0;
            r_ch       <= '0;
            r_pace     <= '0;
            r_tick     <= 1'b0;
            r_prbs     <= PRBS_SEED;
            data_out   <= '0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_tick <= 1'b0;
                if (start_flag) begin
                    r_mode     <= mode;
                    r_seq      <= '0;
                    r_word_idx <= '0;
                    r_ch       <= '0;
                    r_pace     <= '0;
                    r_prbs     <= PRBS_SEED;
                    valid_out  <= 1'b0;
                    last_out   <= 1'b0;
                    frame_cnt  <= '0;
                    drop_cnt   <= '0;
                end
            end else begin
                // Tick is registered once so the first word lands PACE_DIV+1 edges after start
                r_pace <= (r_pace == PACE_MAX) ? '0 : r_pace + 1'b1;
                r_tick <= (r_pace == PACE_MAX);
                if (w_accept) begin
                    valid_out <= 1'b0;
                    last_out  <= 1'b0;
                    if (last_out) frame_cnt <= frame_cnt + 16'd1;
                end
                if (w_load) begin
                    data_out   <= w_word;
                    valid_out  <= 1'b1;
                    last_out   <= (r_word_idx == IDX_MAX);
                    r_word_idx <= (r_word_idx == IDX_MAX) ? '0 : r_word_idx + 1'b1;
                    r_ch       <= (r_ch == CH_MAX) ? '0 : r_ch + 8'd1;
                    r_seq      <= r_seq + 32'd1;
                    r_prbs     <= w_prbs_nxt;
                end
                if (w_drop) begin
                    r_seq <= r_seq + 32'd1;
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule
